// File: rtl/dff_arb_pkg.sv
// ============================================================================
// Module   : dff_arb_pkg
// Purpose  : Shared types and constants for the round-robin D-flop arbiter:
//            the arbiter state encoding, default sizing constants and an
//            index-width helper.
// Ports    : none (package)
// Options  : DFF_ARB_LOCK_EN (consumed by dff_rr_arbiter, not here)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package dff_arb_pkg;

  // Arbiter state: free-running round-robin, or held by a locking owner.
  typedef enum logic [0:0] {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 8;

  // Bits needed to index n requesters; never less than one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int k = 0; k < 32; k++) begin
      if ((1 << r) < n) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_priority_pick.sv
// ============================================================================
// Module   : rr_priority_pick
// Purpose  : Combinational rotating-priority picker. Finds the first set bit
//            of eff_req searching upward from ptr, wrapping NUM_REQ-1 -> 0.
// Ports    : eff_req    in  [NUM_REQ]  eligible requests
//            ptr        in  [IDX_W]    highest-priority index this cycle
//            winner     out [NUM_REQ]  one-hot winner, zero when none
//            winner_idx out [IDX_W]    binary index of winner
//            valid      out            a winner exists
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_pick
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = clog2(DEF_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] eff_req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               valid
);

  // One extra bit so ptr + offset can exceed NUM_REQ-1 before wrapping.
  logic [IDX_W:0] w_cand;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    w_cand     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = {1'b0, ptr} + (IDX_W+1)'(k);
      // ptr < NUM_REQ, so a single subtraction is enough to wrap.
      if (w_cand >= (IDX_W+1)'(NUM_REQ)) w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
      if (!valid && eff_req[w_cand[IDX_W-1:0]]) begin
        valid      = 1'b1;
        winner_idx = w_cand[IDX_W-1:0];
      end
    end
    if (valid) winner[winner_idx] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/dff_rr_arbiter.sv
// ============================================================================
// Module   : dff_rr_arbiter
// Purpose  : Round-robin arbiter sharing one DATA_W-bit output register among
//            NUM_REQ requesters. At most one transfer per cycle; the served
//            requester gets a one-cycle ack and its data is captured.
// Ports    : clk       in                  rising-edge clock
//            reset     in                  synchronous active-high reset
//            req_in    in  [NUM_REQ]       level requests
//            data_in   in  [NUM_REQ*DATA_W] packed data, slice i = requester i
//            lock_in   in  [NUM_REQ]       lock requests (DFF_ARB_LOCK_EN only)
//            gnt_out   out [NUM_REQ]       one-hot grant of current transfer
//            ack_out   out [NUM_REQ]       identical to gnt_out
//            data_out  out [DATA_W]        shared register
//            valid_out out                 data_out newly loaded this cycle
// Options  : DFF_ARB_LOCK_EN - enables lock_in and the LOCKED state
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_rr_arbiter
  import dff_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_in,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
`ifdef DFF_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]        lock_in,
`endif
  output logic [NUM_REQ-1:0]        gnt_out,
  output logic [NUM_REQ-1:0]        ack_out,
  output logic [DATA_W-1:0]         data_out,
  output logic                      valid_out
);

  localparam int         IDX_W     = clog2(NUM_REQ);
  localparam logic [0:0] ST_ARB    = ARB;
  localparam logic [0:0] ST_LOCKED = LOCKED;

  logic [0:0]         r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_owner;
  logic [NUM_REQ-1:0] r_gnt;
  logic [DATA_W-1:0]  r_data;
  logic               r_valid;

  logic [NUM_REQ-1:0] w_lock_vec;
  logic [NUM_REQ-1:0] w_eff_req;
  logic [NUM_REQ-1:0] w_pick_onehot;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;

  logic               w_xfer;
  logic [IDX_W-1:0]   w_xfer_idx;
  logic [NUM_REQ-1:0] w_xfer_onehot;
  logic [DATA_W-1:0]  w_xfer_data;
  logic [0:0]         w_nxt_state;
  logic [IDX_W-1:0]   w_nxt_ptr;
  logic [IDX_W-1:0]   w_nxt_owner;

`ifdef DFF_ARB_LOCK_EN
  assign w_lock_vec = lock_in;
`else
  // Without the lock feature nothing can ever enter LOCKED.
  assign w_lock_vec = '0;
`endif

  // A requester being acked this cycle sits out this round. In LOCKED the
  // picker result is ignored and the owner's raw req_in is used instead, so
  // the owner is effectively exempt from this mask.
  assign w_eff_req = req_in & ~r_gnt;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .eff_req    (w_eff_req),
    .ptr        (r_ptr),
    .winner     (w_pick_onehot),
    .winner_idx (w_pick_idx),
    .valid      (w_pick_valid)
  );

  always_comb begin
    w_xfer        = 1'b0;
    w_xfer_idx    = w_pick_idx;
    w_xfer_onehot = w_pick_onehot;
    w_nxt_state   = r_state;
    w_nxt_ptr     = r_ptr;
    w_nxt_owner   = r_owner;
    if (r_state == ST_LOCKED) begin
      // ptr already sits at owner+1 and is left there.
      w_nxt_state   = ST_ARB;
      w_xfer_idx    = r_owner;
      w_xfer_onehot = '0;
      w_xfer_onehot[r_owner] = 1'b1;
      if (req_in[r_owner]) begin
        w_xfer = 1'b1;
        if (w_lock_vec[r_owner]) w_nxt_state = ST_LOCKED;
      end
    end else if (w_pick_valid) begin
      w_xfer    = 1'b1;
      w_nxt_ptr = (w_pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : w_pick_idx + IDX_W'(1);
      if (w_lock_vec[w_pick_idx]) begin
        w_nxt_state = ST_LOCKED;
        w_nxt_owner = w_pick_idx;
      end
    end
  end

  // Data mux for the transferring requester.
  always_comb begin
    w_xfer_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_xfer_idx == IDX_W'(i)) w_xfer_data = data_in[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ARB;
      r_ptr   <= '0;
      r_owner <= '0;
      r_gnt   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_ptr   <= w_nxt_ptr;
      r_owner <= w_nxt_owner;
      r_valid <= w_xfer;
      r_gnt   <= w_xfer ? w_xfer_onehot : '0;
      if (w_xfer) r_data <= w_xfer_data;
    end
  end

  assign gnt_out   = r_gnt;
  assign ack_out   = r_gnt;
  assign data_out  = r_data;
  assign valid_out = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_dff_rr_arbiter.sv
// ============================================================================
// Module   : tb_dff_rr_arbiter
// Purpose  : Self-checking bench for dff_rr_arbiter (NUM_REQ=4, DATA_W=8).
//            Each cycle the expected grant/data/valid is queued as stimulus
//            is applied, then popped and compared after the next clock edge.
// Options  : DFF_ARB_LOCK_EN - adds the lock scenarios
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dff_rr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [DW-1:0] data;
    logic          valid;
  } exp_t;

  logic             clk;
  logic             reset;
  logic [NR-1:0]    req_in;
  logic [NR*DW-1:0] data_in;
  logic [NR-1:0]    lock_in;
  logic [NR-1:0]    gnt_out;
  logic [NR-1:0]    ack_out;
  logic [DW-1:0]    data_out;
  logic             valid_out;

  exp_t          exp_q[$];
  logic [DW-1:0] last_data;
  int            cyc;
  int            n_checks;
  int            n_errors;

  dff_rr_arbiter #(
    .NUM_REQ (NR),
    .DATA_W  (DW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_in    (req_in),
    .data_in   (data_in),
`ifdef DFF_ARB_LOCK_EN
    .lock_in   (lock_in),
`endif
    .gnt_out   (gnt_out),
    .ack_out   (ack_out),
    .data_out  (data_out),
    .valid_out (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] slice_val(input int c, input int i);
    return DW'((c * 37 + i * 11 + 5) & 255);
  endfunction

  // One clock: apply inputs, queue expectation, step, compare.
  // exp_idx < 0 means no transfer expected.
  task automatic step(input logic rst, input logic [NR-1:0] req,
                      input logic [NR-1:0] lock, input int exp_idx);
    exp_t e;
    exp_t o;
    cyc++;
    reset   = rst;
    req_in  = req;
    lock_in = lock;
    for (int i = 0; i < NR; i++) data_in[i*DW +: DW] = slice_val(cyc, i);
    e = '0;
    if (rst) begin
      last_data = '0;
    end else if (exp_idx >= 0) begin
      e.gnt[exp_idx] = 1'b1;
      e.valid        = 1'b1;
      last_data      = slice_val(cyc, exp_idx);
    end
    e.data = last_data;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    o = exp_q.pop_front();
    check_eq("gnt_out",   32'(gnt_out),   32'(o.gnt));
    check_eq("ack_out",   32'(ack_out),   32'(o.gnt));
    check_eq("data_out",  32'(data_out),  32'(o.data));
    check_eq("valid_out", 32'(valid_out), 32'(o.valid));
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    last_data = '0;
    reset     = 1'b1;
    req_in    = '0;
    lock_in   = '0;
    data_in   = '0;
    @(negedge clk);

    // Reset held with everyone requesting: outputs stay zero.
    for (int k = 0; k < 3; k++) step(1'b1, 4'b1111, 4'b0000, -1);

    // Continuous full request: 0,1,2,3,0,1 one per cycle.
    step(1'b0, 4'b1111, 4'b0000, 0);
    step(1'b0, 4'b1111, 4'b0000, 1);
    step(1'b0, 4'b1111, 4'b0000, 2);
    step(1'b0, 4'b1111, 4'b0000, 3);
    step(1'b0, 4'b1111, 4'b0000, 0);
    step(1'b0, 4'b1111, 4'b0000, 1);

    // ptr=2, requesters 1 and 3: 3 wins first, then 1.
    step(1'b0, 4'b1010, 4'b0000, 3);
    step(1'b0, 4'b1010, 4'b0000, 1);

    // Lone requester held high: served every other cycle.
    step(1'b0, 4'b0001, 4'b0000, 0);
    step(1'b0, 4'b0001, 4'b0000, -1);
    step(1'b0, 4'b0001, 4'b0000, 0);
    step(1'b0, 4'b0001, 4'b0000, -1);

    // Wrap through 3, idle hold, then ptr=0 favours 0 over 3.
    step(1'b0, 4'b1000, 4'b0000, 3);
    for (int k = 0; k < 5; k++) step(1'b0, 4'b0000, 4'b0000, -1);
    step(1'b0, 4'b1001, 4'b0000, 0);

`ifdef DFF_ARB_LOCK_EN
    // ptr=1: 1 first, then 2 locks for four grants, one final grant, then 3.
    step(1'b0, 4'b1111, 4'b0100, 1);
    step(1'b0, 4'b1111, 4'b0100, 2);
    step(1'b0, 4'b1111, 4'b0100, 2);
    step(1'b0, 4'b1111, 4'b0100, 2);
    step(1'b0, 4'b1111, 4'b0100, 2);
    step(1'b0, 4'b1111, 4'b0000, 2);
    step(1'b0, 4'b1111, 4'b0000, 3);
    // Enter LOCKED again, then reset drops it; next grant from ptr=0.
    step(1'b0, 4'b1111, 4'b0100, 0);
    step(1'b0, 4'b1111, 4'b0100, 1);
    step(1'b0, 4'b1111, 4'b0100, 2);
    step(1'b0, 4'b1111, 4'b0100, 2);
    step(1'b1, 4'b1111, 4'b0100, -1);
    step(1'b0, 4'b1111, 4'b0000, 0);
    step(1'b0, 4'b1111, 4'b0000, 1);
`else
    // Reset mid-stream: grant dropped, ptr back to 0.
    step(1'b0, 4'b1111, 4'b0000, 1);
    step(1'b0, 4'b1111, 4'b0000, 2);
    step(1'b1, 4'b1111, 4'b0000, -1);
    step(1'b0, 4'b1110, 4'b0000, 1);
    step(1'b0, 4'b1111, 4'b0000, 2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dff_rr_arbiter.md
# dff_rr_arbiter

Round-robin arbiter that shares a single registered output stage, a DATA_W-bit D-flop bank, between NUM_REQ requesters. Each cycle it picks at most one requesting source, captures that source's data into the shared register and returns a one-cycle acknowledge. It sits between several producer blocks and one downstream consumer of the registered data. An optional lock mode lets a granted requester hold the resource for back-to-back transfers.

## Interface
- NUM_REQ, default 4: number of requesters; must be 2..16.
- DATA_W, default 8: width of each data input and of the shared register.
- clk  input  1: rising-edge clock; all state is updated on this edge.
- reset  input  1: synchronous, active-high reset, sampled on the rising edge of clk.
- req_in  input  NUM_REQ: per-requester request, level.
- data_in  input  NUM_REQ*DATA_W: packed data; slice i belongs to requester i.
- lock_in  input  NUM_REQ: per-requester lock request; present only with DFF_ARB_LOCK_EN.
- gnt_out  output  NUM_REQ: one-hot grant for the current transfer; all zero when idle.
- ack_out  output  NUM_REQ: one-cycle acknowledge pulse to the served requester; equal to gnt_out.
- data_out  output  DATA_W: the shared register, holding the last captured data.
- valid_out  output  1: high for exactly the cycles in which data_out was newly loaded.

## Operation
- Reset values: gnt_out=0, ack_out=0, data_out=0, valid_out=0, round-robin pointer ptr=0, state=ARB.
- Effective request: eff_req = req_in & ~ack_out. A requester whose ack is high in a cycle is not eligible in that same cycle.
- In state ARB, the winner is the first set bit of eff_req, searching upward from ptr and wrapping from NUM_REQ-1 to 0.
- When a winner i exists, on the next edge:
  - gnt_out and ack_out become one-hot at bit i;
  - data_out takes data_in slice i;
  - valid_out becomes 1;
  - ptr becomes (i+1) mod NUM_REQ.
- When eff_req is 0, gnt_out, ack_out and valid_out go to 0. data_out and ptr hold their values.
- A requester that keeps req_in high after its ack cycle counts as a new request. It competes normally from then on.
- Fairness: while all requesters are continuously requesting, each requester is served at least once every 2*NUM_REQ cycles.
- States are ARB and LOCKED. LOCKED is reachable only with DFF_ARB_LOCK_EN.

## Timing
- Latency: req_in and data_in sampled at edge t produce gnt_out, ack_out, data_out and valid_out after edge t (registered, one cycle).
- Peak rate in ARB is one transfer per two cycles for a single requester, and one transfer per cycle when several requesters alternate.
- Simultaneous requests: ptr order decides; a lower index does not win by default.
- ptr wrap-around: a grant to NUM_REQ-1 sets ptr to 0.
- Reset asserted mid-transfer: all outputs and state go to their reset values on that edge. Any in-flight grant or lock is dropped and no ack is issued.
- Reset takes precedence over every other input in the same cycle.

## Configuration
- DFF_ARB_LOCK_EN defined:
  - lock_in exists.
  - A grant to requester i with lock_in[i]=1 moves the state to LOCKED with owner=i.
  - In LOCKED, the ack masking rule is not applied to the owner.
  - req_in[i]=1 and lock_in[i]=1: transfer to i every cycle; stay in LOCKED.
  - req_in[i]=1 and lock_in[i]=0: one final transfer to i, then go to ARB.
  - req_in[i]=0: no transfer, go to ARB.
  - ptr is held at owner+1 throughout LOCKED. Other requesters wait.
- DFF_ARB_LOCK_EN undefined: lock_in is absent and the state is permanently ARB.

## Structure
- Shared package dff_arb_pkg holds:
  - the state enum {ARB, LOCKED};
  - the default NUM_REQ and DATA_W constants;
  - an index-width function clog2(NUM_REQ).
- Sub-module rr_priority_pick: combinational, takes eff_req and ptr, returns a one-hot winner and a valid flag.
- The top level holds ptr, the state, owner and the output registers.

## Test plan
- Reset: hold reset 3 cycles with all req_in=1 → all outputs 0 throughout; after release, the first grant goes to requester 0.
- Round-robin: NUM_REQ=4, all req_in=4'b1111 continuously → grant sequence 0,1,2,3,0,… with one grant per cycle; data_out follows each requester's slice.
- Sparse requests: req_in=4'b1010 with ptr=2 → grant 3 then 1; req_in=4'b0001 held high → grants to 0 on every other cycle.
- Wrap and hold: requester 3 served, then req_in=0 for 5 cycles → valid_out=0, data_out unchanged; next req_in=4'b1001 → grant 0.
- Lock (DFF_ARB_LOCK_EN): requester 2 with lock_in high for 4 cycles while requesters 0, 1 and 3 request → 4 consecutive grants to 2. Drop lock → one final grant to 2, then grant to 3.
- Reset mid-lock: assert reset during LOCKED → state ARB, outputs 0; the next grant follows ptr=0.
